// File: rtl/pila_retorno.sv
// Return-address stack for the 8-bit processor: push stores pc_in+1, pop exposes the top entry.
// Optional PILA_CIRCULAR_EN: a push while full overwrites the oldest entry instead of being rejected.
module pila_retorno #(
    parameter int AW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] pc_in,
    input  logic          err_clr,
    output logic [AW-1:0] pila,
    output logic [CW-1:0] depth_cnt,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_wp;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_pila;
    logic          r_ovf;
    logic          r_udf;

    logic [IW-1:0] w_top;
    logic [IW-1:0] w_below;
    logic [IW-1:0] w_wp_inc;
    logic [AW-1:0] w_data;
    logic          w_empty;
    logic          w_full;
    logic [IW-1:0] w_wp_d;
    logic [CW-1:0] w_cnt_d;
    logic [AW-1:0] w_pila_d;
    logic          w_we;
    logic [IW-1:0] w_waddr;
    logic          w_ovf_set;
    logic          w_udf_set;

    // r_wp is the next write slot; live entries sit just below it, modulo DEPTH.
    assign w_top    = (r_wp == '0) ? LAST_IDX : r_wp - 1'b1;
    assign w_below  = (w_top == '0) ? LAST_IDX : w_top - 1'b1;
    assign w_wp_inc = (r_wp == LAST_IDX) ? '0 : r_wp + 1'b1;
    assign w_data   = pc_in + 1'b1;
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == FULL_CNT);

    always_comb begin
        w_wp_d    = r_wp;
        w_cnt_d   = r_cnt;
        w_pila_d  = r_pila;
        w_we      = 1'b0;
        w_waddr   = r_wp;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (push && pop && !w_empty) begin
            w_we     = 1'b1;
            w_waddr  = w_top;
            w_pila_d = w_data;
        end else if (push) begin
            if (!w_full) begin
                w_we     = 1'b1;
                w_wp_d   = w_wp_inc;
                w_cnt_d  = r_cnt + 1'b1;
                w_pila_d = w_data;
            end else begin
`ifdef PILA_CIRCULAR_EN
                // When full the write slot is the oldest entry; advancing past it drops it.
                w_we     = 1'b1;
                w_wp_d   = w_wp_inc;
                w_pila_d = w_data;
`else
                w_ovf_set = 1'b1;
`endif
            end
        end else if (pop) begin
            if (!w_empty) begin
                w_wp_d   = w_top;
                w_cnt_d  = r_cnt - 1'b1;
                w_pila_d = (r_cnt == CW'(1)) ? '0 : r_mem[w_below];
            end else begin
                w_udf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp   <= '0;
            r_cnt  <= '0;
            r_pila <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            r_wp   <= w_wp_d;
            r_cnt  <= w_cnt_d;
            r_pila <= w_pila_d;
            r_ovf  <= (r_ovf & ~err_clr) | w_ovf_set;
            r_udf  <= (r_udf & ~err_clr) | w_udf_set;
        end
    end

    // Storage is not reset; only the pointer and count define valid contents.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_mem[w_waddr] <= w_data;
        end
    end

    assign pila      = r_pila;
    assign depth_cnt = r_cnt;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
endmodule

// File: tb/tb_pila_retorno.sv
// Self-checking bench for pila_retorno: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pila_retorno;
    localparam int AW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          push;
    logic          pop;
    logic [AW-1:0] pc_in;
    logic          err_clr;
    logic [AW-1:0] pila;
    logic [CW-1:0] depth_cnt;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    logic [AW-1:0] m_q[$];
    bit            m_ovf;
    bit            m_udf;

    pila_retorno #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .pc_in    (pc_in),
        .err_clr  (err_clr),
        .pila     (pila),
        .depth_cnt(depth_cnt),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stack as a queue, newest at the back.
    always @(posedge clk or posedge reset) begin
        bit            so;
        bit            su;
        logic [AW-1:0] nxt;
        so  = 0;
        su  = 0;
        nxt = pc_in + 8'd1;
        if (reset) begin
            m_q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (push && pop && m_q.size() > 0) begin
                m_q[m_q.size() - 1] = nxt;
            end else if (push) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(nxt);
                end else begin
`ifdef PILA_CIRCULAR_EN
                    void'(m_q.pop_front());
                    m_q.push_back(nxt);
`else
                    so = 1;
`endif
                end
            end else if (pop) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
                else su = 1;
            end
            if (err_clr) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (so) m_ovf = 1;
            if (su) m_udf = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_pila", pila, (m_q.size() > 0) ? m_q[m_q.size() - 1] : 8'h00);
            check("m_depth", depth_cnt, m_q.size());
            check("m_empty", empty, m_q.size() == 0);
            check("m_full", full, m_q.size() == DEPTH);
            check("m_ovf", overflow, m_ovf);
            check("m_udf", underflow, m_udf);
        end
    end

    task automatic step(input bit p, input bit o, input logic [AW-1:0] pc, input bit ec);
        push    = p;
        pop     = o;
        pc_in   = pc;
        err_clr = ec;
        @(posedge clk);
        #1;
        push    = 0;
        pop     = 0;
        err_clr = 0;
    endtask

    // Pop while checking the value the PC would capture at this edge.
    task automatic pop_sample(input string name, input logic [AW-1:0] exp);
        pop = 1;
        @(negedge clk);
        check(name, pila, exp);
        @(posedge clk);
        #1;
        pop = 0;
    endtask

    initial begin
        reset   = 1;
        push    = 0;
        pop     = 0;
        pc_in   = '0;
        err_clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        check("rst_pila", pila, 8'h00);
        check("rst_depth", depth_cnt, 0);
        check("rst_empty", empty, 1);
        check("rst_flags", {overflow, underflow, full}, 3'b000);

        step(1, 0, 8'h10, 0); check("push1", pila, 8'h11);
        step(1, 0, 8'h20, 0); check("push2", pila, 8'h21);
        step(1, 0, 8'h30, 0); check("push3", pila, 8'h31);
        check("depth3", depth_cnt, 3);
        check("not_empty", empty, 0);

        pop_sample("pop_pc1", 8'h31);
        pop_sample("pop_pc2", 8'h21);
        pop_sample("pop_pc3", 8'h11);
        check("pila_empty", pila, 8'h00);
        check("empty_after", empty, 1);
        step(0, 1, 8'h00, 0);
        check("underflow", underflow, 1);
        check("udf_pila", pila, 8'h00);

        step(1, 0, 8'hFF, 0); check("wrap", pila, 8'h00);
        step(1, 1, 8'h40, 0); check("replace", pila, 8'h41);
        check("replace_depth", depth_cnt, 1);
        check("replace_udf", underflow, 1);
        step(0, 0, 8'h00, 1); check("udf_clr", underflow, 0);
        step(1, 1, 8'h50, 0); check("pushpop_nodrop", depth_cnt, 1);
        step(0, 1, 8'h00, 0); check("pop_to_empty", empty, 1);
        step(1, 1, 8'h60, 0); check("pp_empty_pila", pila, 8'h61);
        check("pp_empty_udf", underflow, 0);
        step(0, 1, 8'h00, 0);

        for (int i = 0; i <= DEPTH; i++) step(1, 0, 8'(i), 0);
`ifdef PILA_CIRCULAR_EN
        check("circ_ovf", overflow, 0);
        check("circ_pila", pila, 8'h09);
        check("circ_full", full, 1);
        for (int i = 0; i < DEPTH; i++) pop_sample("circ_pop", 8'(9 - i));
        check("circ_empty", empty, 1);
`else
        check("full", full, 1);
        check("overflow", overflow, 1);
        check("full_pila", pila, 8'h08);
        step(0, 0, 8'h00, 1); check("ovf_clr", overflow, 0);
        step(1, 0, 8'h77, 1); check("ovf_set_wins", overflow, 1);
        check("ovf_pila_hold", pila, 8'h08);
        for (int i = 0; i < DEPTH; i++) pop_sample("lifo_pop", 8'(8 - i));
`endif
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 1); check("udf_set_wins", underflow, 1);
        step(0, 0, 8'h00, 1);

        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h80 + i), 0);
        check("depth5", depth_cnt, 5);
        push  = 1;
        pc_in = 8'hA0;
        #2 reset = 1;
        #1;
        check("arst_pila", pila, 8'h00);
        check("arst_depth", depth_cnt, 0);
        check("arst_empty", empty, 1);
        check("arst_flags", {full, overflow, underflow}, 3'b000);
        push = 0;
        @(negedge clk);
        #1 reset = 0;
        step(0, 0, 8'h00, 0);
        check("post_rst_depth", depth_cnt, 0);
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pila_retorno.md
Name: pila_retorno

Overview:
- Hardware return-address stack ("pila") for the 8-bit Von Neumann processor.
- Opposite end of the program counter's return path:
  - On a call, the control unit asserts push and the block stores PC+1.
  - On a return, the control unit asserts pop while driving the PC's "load from pila" code; the PC captures the pila output at that same edge.
- Sits between the control unit and the program counter.
- Provides occupancy status and sticky error flags for debug.

Parameters:
- AW, 8, address width; width of pc_in and pila.
- DEPTH, 8, number of stack entries; minimum 2.
- CW, $clog2(DEPTH+1), width of depth_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  call: store pc_in+1 on top of the stack.
- pop  input  1  return: remove the top entry.
- pc_in  input  AW  current PC value at the time of the call.
- err_clr  input  1  synchronous clear of the sticky flags.
- pila  output  AW  registered copy of the top entry; 0 when empty.
- depth_cnt  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  depth_cnt==0.
- full  output  1  depth_cnt==DEPTH.
- overflow  output  1  sticky: a push was rejected because the stack was full.
- underflow  output  1  sticky: a pop was rejected because the stack was empty.

Behaviour:
- Clocking: clock clk, rising edge. Reset: reset, asynchronous, active-high.
- Reset values: pila=0, depth_cnt=0, empty=1, full=0, overflow=0, underflow=0.
- Reset clears the stack pointer only; stored memory contents are don't-care. Reset asserted mid-operation aborts any pending push/pop with no partial update.
- Push data: (pc_in + 1) mod 2^AW. Example: pc_in=0xFF stores 0x00.
- Invariant: pila always equals the top entry, or 0 when empty. Because pila is registered, it is valid for the whole cycle after any update.
- Pop timing: during a pop cycle, pila still shows the entry being removed, so the PC loading pila at the same edge gets the correct return address. pila shows the new top one cycle later.
- push=1, pop=0, not full: write entry, depth_cnt+1, pila<=pc_in+1.
- push=1, pop=0, full: see Optional Feature.
- pop=1, push=0, not empty: depth_cnt-1; pila<=next entry below, or 0 if the stack becomes empty.
- pop=1, push=0, empty: no state change except underflow<=1; pila stays 0.
- push=1, pop=1, not empty: replace the top entry with pc_in+1; depth_cnt unchanged; pila<=pc_in+1; no flags set. This covers return-then-call in the same cycle.
- push=1, pop=1, empty: treated as push only; no underflow.
- Neither push nor pop: hold all state.
- err_clr=1 clears overflow and underflow. If a new error occurs in the same cycle, the set wins.
- Status outputs (empty, full, depth_cnt) are registered and change in the same cycle as the corresponding pila update.

Optional Feature:
- Macro: PILA_CIRCULAR_EN.
- Defined (circular mode):
  - A push while full overwrites the oldest entry using a circular base pointer.
  - depth_cnt stays at DEPTH; pila<=pc_in+1.
  - overflow is not set.
  - DEPTH subsequent pops return the newest DEPTH addresses in LIFO order.
- Undefined (default):
  - A push while full is ignored: memory, depth_cnt and pila are unchanged.
  - overflow<=1.

Test Plan:
- Reset, then push with pc_in=0x10, 0x20, 0x30 -> pila=0x11, 0x21, 0x31 after each edge; depth_cnt=3; empty=0.
- From that state, pop 3x -> the PC-sampled pila values in the pop cycles are 0x31, 0x21, 0x11; afterwards pila=0, empty=1. A 4th pop sets underflow=1 and pila stays 0.
- Push with pc_in=0xFF -> pila=0x00. Then assert push and pop together with pc_in=0x40 -> pila=0x41, depth_cnt=1.
- Push DEPTH+1 times with pc_in=0x00..0x08:
  - Macro off: full=1, overflow=1, pila=0x08.
  - Macro on: overflow=0, pila=0x09, and 8 pops return 0x09 down to 0x02.
- Set overflow, then assert err_clr with an idle stack -> overflow=0. Repeat with err_clr and a rejected push in the same cycle -> overflow stays 1.
- Assert reset asynchronously mid-push with depth_cnt=5 -> all outputs go to reset values immediately, without waiting for a clock edge.
